// File: rtl/rtc_bus_arbiter.sv
// Shares the multiplexed RTC address/data bus between NREQ requesters, running the
// address/data strobe sequence. Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module rtc_bus_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned T_PULSE = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [8*NREQ-1:0] addr,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              a_d,
  output logic [7:0]        ad_out,
  output logic              ad_oe,
  input  logic [7:0]        ad_in
);

  localparam int unsigned CW = $clog2(T_PULSE + 1);
  localparam int unsigned IW = $clog2(NREQ);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAddrStb = 3'd1;
  localparam logic [2:0] StAddrGap = 3'd2;
  localparam logic [2:0] StDataStb = 3'd3;
  localparam logic [2:0] StDataGap = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          adv;
  logic          we_q;
  logic [7:0]    addr_q, wdata_q;

  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic          sel_we;
  logic [7:0]    sel_addr, sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gidx_q;
  logic [IW-1:0] cand;

  // Search starts just past the last served requester.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= IW'(NREQ - 1);
      gidx_q <= '0;
    end else begin
      if (state_q == StIdle && win_valid) gidx_q <= win_idx;
      if (state_q == StDone) ptr_q <= gidx_q;
    end
  end
`else
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!win_valid && req[IW'(k)]) begin
        win_valid = 1'b1;
        win_idx   = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_idx == IW'(k)) begin
        sel_we    = we[k];
        sel_addr  = addr[8*k +: 8];
        sel_wdata = wdata[8*k +: 8];
      end
    end
  end

  assign adv = (cnt_q == CW'(T_PULSE - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (win_valid) state_d = StAddrStb;
      StAddrStb: if (adv) state_d = StAddrGap;
      StAddrGap: if (adv) state_d = StDataStb;
      StDataStb: if (adv) state_d = StDataGap;
      StDataGap: if (adv) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || state_q == StIdle || state_q == StDone) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt     <= '0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && win_valid) begin
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
      end else if (state_q == StDone) begin
        gnt <= '0;
      end
      if (state_q == StDataStb && adv && !we_q) rdata <= ad_in;
    end
  end

  // Pin and done outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      a_d    <= 1'b0;
      ad_oe  <= 1'b0;
      ad_out <= '0;
      done   <= '0;
    end else begin
      cs_n  <= !(state_q == StAddrStb || state_q == StDataStb);
      wr_n  <= !(state_q == StAddrStb || (state_q == StDataStb && we_q));
      rd_n  <= !(state_q == StDataStb && !we_q);
      a_d   <= (state_q == StDataStb || state_q == StDataGap);
      ad_oe <= (state_q == StAddrStb || state_q == StAddrGap ||
                (state_q == StDataStb && we_q));
      if (state_q == StAddrStb || state_q == StAddrGap) ad_out <= addr_q;
      else if (state_q == StDataStb && we_q)             ad_out <= wdata_q;
      else                                               ad_out <= '0;
      done <= (state_q == StDone) ? gnt : '0;
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed self-checking bench for rtc_bus_arbiter with T_PULSE=4, NREQ=4.
module tb_rtc_bus_arbiter;
  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   we = '0;
  logic [8*NREQ-1:0] addr = '0;
  logic [8*NREQ-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        rdata, ad_out, ad_in;
  logic              busy, cs_n, rd_n, wr_n, a_d, ad_oe;
  logic [7:0]        rtc_val = 8'h09;

  int checks = 0;
  int passes = 0;

  rtc_bus_arbiter #(.NREQ(NREQ), .T_PULSE(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n), .a_d(a_d), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  // The RTC drives the bus only while its read strobe is low.
  assign ad_in = rd_n ? 8'h00 : rtc_val;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pins {cs_n,wr_n,rd_n,a_d,ad_oe,ad_out} c cycles after gnt rises; ad_out shown as 0 when not driven.
  function automatic logic [12:0] exp_pins(int c, logic w, logic [7:0] a, logic [7:0] d);
    case ((c - 1) / 4)
      0: return {5'b00101, a};
      1: return {5'b11101, a};
      2: return w ? {5'b00111, d} : {5'b01010, 8'h00};
      3: return {5'b11110, 8'h00};
      default: return {5'b11100, 8'h00};
    endcase
  endfunction

  function automatic logic [12:0] obs_pins();
    return {cs_n, wr_n, rd_n, a_d, ad_oe, (ad_oe ? ad_out : 8'h00)};
  endfunction

  task automatic wait_gnt();
    int n = 0;
    while (gnt == '0 && n < 8) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe} !== 5'b11100) $display("FAIL reset_strobes got %b want 11100", {cs_n, rd_n, wr_n, a_d, ad_oe});
    else passes++;
    checks++;
    if (ad_out !== 8'h00) $display("FAIL reset_ad_out got %h want 00", ad_out);
    else passes++;
    checks++;
    if ({gnt, done} !== 8'h00) $display("FAIL reset_gnt_done got %b want 00000000", {gnt, done});
    else passes++;
    checks++;
    if ({rdata, busy} !== 9'h000) $display("FAIL reset_rdata_busy got %h/%b want 00/0", rdata, busy);
    else passes++;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_idle_quiet();
    req = '0;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if ({busy, gnt, cs_n, rd_n, wr_n, ad_oe} !== {1'b0, 4'b0000, 4'b1110})
        $display("FAIL idle_quiet cyc %0d got %b want 000001110", c, {busy, gnt, cs_n, rd_n, wr_n, ad_oe});
      else passes++;
    end
  endtask

  // Runs one transaction for requester i and checks every cycle through done.
  task automatic run_single(string nm, int i, logic w, logic [7:0] a, logic [7:0] d);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    we[i] = w;
    addr[8*i +: 8] = a;
    wdata[8*i +: 8] = d;
    req[i] = 1'b1;
    wait_gnt();
    checks++;
    if (gnt !== oh) $display("FAIL %s_gnt got %b want %b", nm, gnt, oh);
    else passes++;
    req[i] = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      checks++;
      if (obs_pins() !== exp_pins(c, w, a, d))
        $display("FAIL %s_pins cyc %0d got %h want %h", nm, c, obs_pins(), exp_pins(c, w, a, d));
      else passes++;
      checks++;
      if ({gnt, done} !== ((c == 17) ? {4'b0000, oh} : {oh, 4'b0000}))
        $display("FAIL %s_gnt_done cyc %0d got %b", nm, c, {gnt, done});
      else passes++;
    end
  endtask

  task automatic test_single_write();
    run_single("write", 1, 1'b1, 8'h21, 8'h17);
    tick();
  endtask

  task automatic test_single_read();
    run_single("read", 0, 1'b0, 8'h24, 8'h00);
    checks++;
    if (rdata !== 8'h09) $display("FAIL read_rdata got %h want 09", rdata);
    else passes++;
    tick();
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] order [5];
`ifdef ARB_ROUND_ROBIN_EN
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we = '0;
    req = 4'b1111;
    wait_gnt();
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (gnt !== order[n]) $display("FAIL contention_gnt %0d got %b want %b", n, gnt, order[n]);
      else passes++;
      repeat (17) tick();
      checks++;
      if (done !== order[n]) $display("FAIL contention_done %0d got %b want %b", n, done, order[n]);
      else passes++;
      if (n == 4) req = '0;
      tick();
    end
  endtask

  task automatic test_input_change();
    we[1] = 1'b1;
    addr[15:8] = 8'h3C;
    wdata[15:8] = 8'hA5;
    req[1] = 1'b1;
    wait_gnt();
    checks++;
    if (gnt !== 4'b0010) $display("FAIL chg_gnt got %b want 0010", gnt);
    else passes++;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 5) begin
        addr[15:8] = 8'hFF;
        wdata[15:8] = 8'hFF;
        req[1] = 1'b0;
      end
      if (c == 6 || c == 10) begin
        checks++;
        if (obs_pins() !== exp_pins(c, 1'b1, 8'h3C, 8'hA5))
          $display("FAIL chg_pins cyc %0d got %h want %h", c, obs_pins(), exp_pins(c, 1'b1, 8'h3C, 8'hA5));
        else passes++;
      end
    end
    checks++;
    if (done !== 4'b0010) $display("FAIL chg_done got %b want 0010", done);
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    we[2] = 1'b1;
    addr[23:16] = 8'h55;
    wdata[23:16] = 8'h66;
    req[2] = 1'b1;
    wait_gnt();
    repeat (10) tick();
    checks++;
    if (obs_pins() !== exp_pins(10, 1'b1, 8'h55, 8'h66))
      $display("FAIL mid_pins_before got %h want %h", obs_pins(), exp_pins(10, 1'b1, 8'h55, 8'h66));
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({cs_n, wr_n, rd_n, ad_oe, gnt, done} !== {4'b1110, 8'h00})
      $display("FAIL mid_abort got %b want 111000000000", {cs_n, wr_n, rd_n, ad_oe, gnt, done});
    else passes++;
    tick();
    tick();
    checks++;
    if ({done, busy} !== 5'b00000) $display("FAIL mid_no_done got %b want 00000", {done, busy});
    else passes++;
    req = 4'b0101;
    we[0] = 1'b0;
    reset = 1'b0;
    wait_gnt();
    checks++;
    if (gnt !== 4'b0001) $display("FAIL mid_first_gnt got %b want 0001", gnt);
    else passes++;
    req = '0;
    repeat (17) tick();
    checks++;
    if (done !== 4'b0001) $display("FAIL mid_done got %b want 0001", done);
    else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_quiet();
    test_single_write();
    test_single_read();
    test_contention();
    test_input_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
